mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Arbitrates the single byte-wide RAM/IO port between the ICache miss path and the load/store buffer (LSB).
- Serialises 1/2/4-byte accesses into byte beats.
- Reassembles read bytes little-endian into 32-bit words.
- Returns one-cycle completion pulses.
- Sits directly downstream of the ICache: it consumes the ICache's mem_enable/inst_addr and feeds back inst/mem_valid.

Parameters:
IO_BASE, 32'h00030000, addresses >= IO_BASE are memory-mapped IO; stores there obey io_buffer_full.

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
rdy  in  1  global ready; low freezes the block
mem_din  in  8  RAM read data; byte for the address presented in cycle N is valid in cycle N+1
mem_dout  out  8  RAM write data
mem_a  out  32  RAM address
mem_wr  out  1  RAM write enable (1 = write)
io_buffer_full  in  1  IO write buffer full
inst_req  in  1  ICache fetch request (ICache mem_enable); level, held until inst_valid
inst_addr  in  32  ICache fetch address, word aligned
inst_valid  out  1  one-cycle pulse; inst_data valid
inst_data  out  32  fetched instruction word
ls_req  in  1  LSB request; level, held until ls_done
ls_wr  in  1  1 = store, 0 = load
ls_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
ls_addr  in  32  load/store address
ls_wdata  in  32  store data; low ls_size bytes used
ls_done  out  1  one-cycle pulse; load data valid / store finished
ls_rdata  out  32  load data, zero-extended (LSB sign-extends)
rollback  in  1  pipeline flush from ROB

Behaviour:
- Reset:
  - state = IDLE, counters cleared.
  - mem_a = 0, mem_dout = 0, mem_wr = 0.
  - inst_valid = 0, inst_data = 0.
  - ls_done = 0, ls_rdata = 0.
- rdy low: all registers hold, no pulse is generated or consumed, and the mem_wr output is gated to 0 (mem_wr = wr_reg & rdy).
- States: IDLE, IFETCH, LOAD, STORE, COOL.
- IDLE accept (at the edge where the request is sampled):
  - ls_req has priority over inst_req.
  - Latch addr, n = 1/2/4 bytes, and direction; clear byte counter k.
  - Go to LOAD, STORE, or IFETCH (n = 4).
- Read (IFETCH/LOAD):
  - mem_wr = 0.
  - mem_a = addr+k is issued on the accept edge and on each following edge, for k = 0..n-1.
  - The byte for beat k is captured from mem_din at accept edge + k + 2 into bits [8k+7:8k].
  - On the edge capturing the last byte (accept + n + 1), drive the full word on inst_data or ls_rdata, pulse inst_valid or ls_done for 1 cycle, and go to COOL.
  - Unused upper bytes of ls_rdata = 0.
- Store (STORE):
  - On the accept edge and each following edge, drive mem_wr = 1, mem_a = addr+k, mem_dout = ls_wdata[8k+7:8k], for k = 0..n-1.
  - At accept + n: mem_wr = 0, pulse ls_done, go to COOL.
- IO store gating:
  - A store with ls_addr >= IO_BASE is not accepted while io_buffer_full = 1; it waits in IDLE.
  - A pending inst_req may be served meanwhile.
  - Once accepted, the store completes regardless of io_buffer_full.
- COOL:
  - Lasts exactly 1 cycle; requests are ignored; mem_wr = 0; then go to IDLE.
  - Purpose: requesters drop their request one edge after seeing the done pulse, so COOL prevents a duplicate re-issue.
- Abort: when rollback = 1, or inst_req drops during IFETCH:
  - IFETCH and LOAD abort at that edge: no pulse, go to IDLE, mem_wr = 0.
  - STORE is never aborted: it is committed and runs to completion, including ls_done.
  - rollback in IDLE or COOL has no effect except that requests sampled that same edge are not accepted.
- Simultaneous inst_req and ls_req in IDLE: LSB is served first; the ICache request stays pending and is accepted on the first IDLE after COOL.
- Address arithmetic is 32-bit wrap-around; no alignment checks.
- rst mid-operation: immediate return to reset values and no pulse, even in STORE (a partial write is acceptable).

Test Plan:
1. IFETCH: inst_req = 1, inst_addr = 0x100, RAM[0x100..0x103] = 13,05,A0,00 -> mem_a 0x100..0x103 on consecutive cycles; inst_valid pulses 5 cycles after accept with inst_data = 0x00A00513; no re-fetch during COOL while inst_req is still high.
2. Store half: ls_req, ls_wr = 1, ls_size = 01, ls_addr = 0x204, ls_wdata = 0xDEADBEEF -> mem_wr = 1 with (0x204, EF), then (0x205, BE); ls_done on the 3rd edge; RAM[0x206] unchanged.
3. Arbitration: inst_req and load-byte from 0x10 (RAM = 0x80) asserted together -> ls_done first with ls_rdata = 0x00000080; then fetch accepted after COOL; inst_valid follows.
4. Rollback: start IFETCH at 0x0 and assert rollback after 2 beats -> no inst_valid, IDLE next cycle; repeat during STORE word -> all 4 bytes written and ls_done asserted.
5. IO gating: store byte to 0x30000 with io_buffer_full = 1 for 6 cycles -> mem_wr stays 0; after the flag clears, a single write (0x30000, data) and ls_done.
6. rdy: drop rdy for 3 cycles mid-LOAD word -> mem_wr = 0 and no state advance while low; after resume, ls_rdata is correct and exactly one ls_done pulse occurs.

Source files
------------

// File: rtl/mem_controller_if.sv
// Bundles the memory controller's byte-wide RAM/IO port, the ICache miss
// path, the load/store buffer path and the global rdy/rollback controls.
// "slave" is the view taken by the controller. "master" is the view taken by
// the surrounding CPU, which owns the requesters and the RAM.
interface mem_controller_if;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        rollback;

    modport slave (
        input  rdy, mem_din, io_buffer_full,
        input  inst_req, inst_addr,
        input  ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  rollback,
        output mem_dout, mem_a, mem_wr,
        output inst_valid, inst_data,
        output ls_done, ls_rdata
    );

    modport master (
        output rdy, mem_din, io_buffer_full,
        output inst_req, inst_addr,
        output ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output rollback,
        input  mem_dout, mem_a, mem_wr,
        input  inst_valid, inst_data,
        input  ls_done, ls_rdata
    );
endinterface

// File: rtl/mem_controller.sv
// Memory controller: arbitrates the single byte-wide RAM/IO port between the
// ICache miss path and the load/store buffer. It serialises 1/2/4-byte
// accesses into byte beats, reassembles read bytes little-endian, and returns
// one-cycle completion pulses. After every completed access there is a
// one-cycle COOL state. This lets the requester drop its level request
// before it could be sampled again.
module mem_controller #(
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic clk,
    input  logic rst,
    mem_controller_if.slave bus
);

    typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, COOL} state_t;

    state_t      state, next_state;

    logic [31:0] addr;          // base address of the current access
    logic [31:0] wdata;         // latched store data
    logic [2:0]  len;           // bytes in the access: 1, 2 or 4
    logic [2:0]  cnt;           // edges since accept; drives issue and capture
    logic [31:0] rbuf;          // read bytes gathered so far
    logic [31:0] read_word;     // rbuf with the byte arriving this cycle merged
    logic [1:0]  byte_idx;

    logic [31:0] mem_a_r;
    logic [7:0]  mem_dout_r;
    logic        wr_r;
    logic        inst_valid_r;
    logic [31:0] inst_data_r;
    logic        ls_done_r;
    logic [31:0] ls_rdata_r;

    logic        held;          // previous edge was frozen by rdy low
    logic [7:0]  din_save;      // mem_din seen in the first frozen cycle
    logic [7:0]  din_eff;

    logic [2:0]  ls_len;
    logic        io_block;
    logic        ls_take;
    logic        accept_ls;
    logic        accept_inst;
    logic        abort;
    logic        finish_read;
    logic        finish_store;

    // Decode the LSB request: byte count, and whether an IO store must wait
    always_comb begin
        ls_len = 3'd4;
        case (bus.ls_size)
            2'b00:   ls_len = 3'd1;
            2'b01:   ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
        io_block = bus.ls_req & bus.ls_wr & (bus.ls_addr >= IO_BASE) & bus.io_buffer_full;
        ls_take  = bus.ls_req & ~io_block;
    end

    // Next-state logic and per-edge control strobes
    always_comb begin
        next_state   = state;
        accept_ls    = 1'b0;
        accept_inst  = 1'b0;
        abort        = 1'b0;
        finish_read  = 1'b0;
        finish_store = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.rollback) begin
                    if (ls_take) begin
                        accept_ls  = 1'b1;
                        next_state = bus.ls_wr ? STORE : LOAD;
                    end else if (bus.inst_req) begin
                        accept_inst = 1'b1;
                        next_state  = IFETCH;
                    end
                end
            end
            IFETCH, LOAD: begin
                if (bus.rollback || (state == IFETCH && !bus.inst_req)) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (cnt == len + 3'd1) begin
                    finish_read = 1'b1;
                    next_state  = COOL;
                end
            end
            STORE: begin
                // Stores are committed; rollback cannot cut them short
                if (cnt == len) begin
                    finish_store = 1'b1;
                    next_state   = COOL;
                end
            end
            COOL:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; rdy low freezes the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.rdy) begin
            state <= next_state;
        end
    end

    // The RAM keeps answering while rdy is low. mem_din then shows the byte
    // for the held address. The byte that was in flight shows up only in the
    // first frozen cycle, so keep it for the resume edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            held     <= 1'b0;
            din_save <= 8'd0;
        end else if (!bus.rdy) begin
            if (!held) begin
                din_save <= bus.mem_din;
            end
            held <= 1'b1;
        end else begin
            held <= 1'b0;
        end
    end

    // Merge the byte that arrives this cycle into its little-endian lane
    always_comb begin
        din_eff   = held ? din_save : bus.mem_din;
        byte_idx  = cnt[1:0] - 2'd2;
        read_word = rbuf;
        read_word[{byte_idx, 3'b000} +: 8] = din_eff;
    end

    // Beat sequencing, RAM port drive, read assembly and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= 32'd0;
            wdata        <= 32'd0;
            len          <= 3'd0;
            cnt          <= 3'd0;
            rbuf         <= 32'd0;
            mem_a_r      <= 32'd0;
            mem_dout_r   <= 8'd0;
            wr_r         <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_data_r  <= 32'd0;
            ls_done_r    <= 1'b0;
            ls_rdata_r   <= 32'd0;
        end else if (bus.rdy) begin
            inst_valid_r <= 1'b0;
            ls_done_r    <= 1'b0;
            case (state)
                IDLE: begin
                    wr_r <= 1'b0;
                    if (accept_ls) begin
                        addr    <= bus.ls_addr;
                        len     <= ls_len;
                        wdata   <= bus.ls_wdata;
                        cnt     <= 3'd1;
                        rbuf    <= 32'd0;
                        mem_a_r <= bus.ls_addr;
                        wr_r    <= bus.ls_wr;
                        if (bus.ls_wr) begin
                            mem_dout_r <= bus.ls_wdata[7:0];
                        end
                    end else if (accept_inst) begin
                        addr    <= bus.inst_addr;
                        len     <= 3'd4;
                        cnt     <= 3'd1;
                        rbuf    <= 32'd0;
                        mem_a_r <= bus.inst_addr;
                    end
                end
                IFETCH, LOAD: begin
                    wr_r <= 1'b0;
                    if (!abort) begin
                        cnt <= cnt + 3'd1;
                        if (cnt < len) begin
                            mem_a_r <= addr + 32'(cnt);
                        end
                        if (cnt >= 3'd2) begin
                            rbuf <= read_word;
                        end
                        if (finish_read) begin
                            if (state == IFETCH) begin
                                inst_data_r  <= read_word;
                                inst_valid_r <= 1'b1;
                            end else begin
                                ls_rdata_r <= read_word;
                                ls_done_r  <= 1'b1;
                            end
                        end
                    end
                end
                STORE: begin
                    if (finish_store) begin
                        wr_r      <= 1'b0;
                        ls_done_r <= 1'b1;
                    end else begin
                        wr_r       <= 1'b1;
                        mem_a_r    <= addr + 32'(cnt);
                        mem_dout_r <= wdata[{cnt[1:0], 3'b000} +: 8];
                        cnt        <= cnt + 3'd1;
                    end
                end
                default: wr_r <= 1'b0;
            endcase
        end
    end

    assign bus.mem_a      = mem_a_r;
    assign bus.mem_dout   = mem_dout_r;
    assign bus.mem_wr     = wr_r & bus.rdy;
    assign bus.inst_valid = inst_valid_r;
    assign bus.inst_data  = inst_data_r;
    assign bus.ls_done    = ls_done_r;
    assign bus.ls_rdata   = ls_rdata_r;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: a byte RAM model with one-cycle read latency,
// directed steps for fetch, store, arbitration, rollback, IO gating and rdy
// stalls, and scoreboard queues for RAM writes and completion pulses.
module tb_mem_controller;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit          load;
        logic [31:0] data;
    } ls_t;

    logic clk = 1'b0;
    logic rst;

    mem_controller_if bus();

    mem_controller #(.IO_BASE(32'h00030000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int inst_pulses = 0;

    wr_t         wr_q[$];
    ls_t         ls_q[$];
    logic [31:0] inst_q[$];
    wr_t         we;
    ls_t         le;
    logic [31:0] ie;

    // RAM model: the byte for the address in cycle N appears in cycle N+1
    logic [7:0]  ram [0:262143];
    logic [7:0]  ram_q;
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        ram_q <= ram[bus.mem_a[17:0]];
        if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
        else if (pl_en) ram[pl_addr] <= pl_data;
    end

    assign bus.mem_din = ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [17:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            pl_addr = a + 18'(i);
            pl_data = w[i*8 +: 8];
            pl_en   = 1'b1;
            tick();
        end
        pl_en = 1'b0;
    endtask

    task automatic wait_ls(input string tag, input int budget);
        int n = 0;
        while (bus.ls_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(bus.ls_done), 32'd1);
    endtask

    task automatic wait_inst(input string tag, input int budget);
        int n = 0;
        while (bus.inst_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    endtask

    // Scoreboard: every write beat and completion pulse must be expected
    always @(negedge clk) begin
        if (!rst && bus.rdy) begin
            if (bus.mem_wr) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    check("wr_addr", bus.mem_a, we.addr);
                    check("wr_data", {24'd0, bus.mem_dout}, {24'd0, we.data});
                end
            end
            if (bus.inst_valid) begin
                inst_pulses++;
                check("inst_expected", 32'(inst_q.size() != 0), 32'd1);
                if (inst_q.size() != 0) begin
                    ie = inst_q.pop_front();
                    check("inst_data", bus.inst_data, ie);
                end
            end
            if (bus.ls_done) begin
                check("ls_expected", 32'(ls_q.size() != 0), 32'd1);
                if (ls_q.size() != 0) begin
                    le = ls_q.pop_front();
                    if (le.load) check("ls_rdata", bus.ls_rdata, le.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses_before;
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.inst_req = 1'b0;
        bus.inst_addr = 32'd0;
        bus.ls_req = 1'b0;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'b00;
        bus.ls_addr = 32'd0;
        bus.ls_wdata = 32'd0;
        bus.rollback = 1'b0;
        pl_en = 1'b0;
        pl_addr = 18'd0;
        pl_data = 8'd0;

        // Preload RAM while reset is held
        preload(18'h00100, 32'h00A00513);
        preload(18'h00010, 32'h00000080);
        preload(18'h00204, 32'h77665544);
        preload(18'h00000, 32'hCAFEF00D);
        preload(18'h00300, 32'hFFFFFFFF);
        preload(18'h00400, 32'h12345678);
        preload(18'h30000, 32'h00000000);

        // Reset state
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
        check("rst_ls_done", 32'(bus.ls_done), 32'd0);
        check("rst_ls_rdata", bus.ls_rdata, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // 1. Instruction fetch of a word at 0x100
        inst_q.push_back(32'h00A00513);
        bus.inst_addr = 32'h100;
        bus.inst_req = 1'b1;
        tick();
        check("if_a0", bus.mem_a, 32'h100);
        tick();
        check("if_a1", bus.mem_a, 32'h101);
        tick();
        check("if_a2", bus.mem_a, 32'h102);
        tick();
        check("if_a3", bus.mem_a, 32'h103);
        check("if_wr", 32'(bus.mem_wr), 32'd0);
        tick();
        check("if_early", 32'(bus.inst_valid), 32'd0);
        tick();
        check("if_valid", 32'(bus.inst_valid), 32'd1);
        check("if_word", bus.inst_data, 32'h00A00513);
        tick();
        check("if_pulse_len", 32'(bus.inst_valid), 32'd0);
        bus.inst_req = 1'b0;
        tick();
        tick();
        check("if_no_refetch", bus.mem_a, 32'h103);

        // 2. Half-word store at 0x204
        wr_q.push_back('{32'h204, 8'hEF});
        wr_q.push_back('{32'h205, 8'hBE});
        ls_q.push_back('{1'b0, 32'd0});
        bus.ls_req = 1'b1;
        bus.ls_wr = 1'b1;
        bus.ls_size = 2'b01;
        bus.ls_addr = 32'h204;
        bus.ls_wdata = 32'hDEADBEEF;
        tick();
        check("sh_wr0", 32'(bus.mem_wr), 32'd1);
        check("sh_a0", bus.mem_a, 32'h204);
        check("sh_d0", {24'd0, bus.mem_dout}, 32'hEF);
        tick();
        check("sh_a1", bus.mem_a, 32'h205);
        check("sh_d1", {24'd0, bus.mem_dout}, 32'hBE);
        tick();
        check("sh_done", 32'(bus.ls_done), 32'd1);
        check("sh_wr_off", 32'(bus.mem_wr), 32'd0);
        tick();
        bus.ls_req = 1'b0;
        bus.ls_wr = 1'b0;
        tick();
        check("sh_ram204", {24'd0, ram[18'h204]}, 32'hEF);
        check("sh_ram205", {24'd0, ram[18'h205]}, 32'hBE);
        check("sh_ram206", {24'd0, ram[18'h206]}, 32'h66);

        // 3. Arbitration: load byte and fetch requested together
        ls_q.push_back('{1'b1, 32'h00000080});
        inst_q.push_back(32'h00A00513);
        pulses_before = inst_pulses;
        bus.inst_addr = 32'h100;
        bus.inst_req = 1'b1;
        bus.ls_req = 1'b1;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'b00;
        bus.ls_addr = 32'h10;
        wait_ls("arb_ls", 6);
        check("arb_rdata", bus.ls_rdata, 32'h00000080);
        check("arb_ls_first", 32'(inst_pulses), 32'(pulses_before));
        tick();
        bus.ls_req = 1'b0;
        wait_inst("arb_if", 12);
        check("arb_word", bus.inst_data, 32'h00A00513);
        tick();
        bus.inst_req = 1'b0;
        tick();

        // 4. Rollback aborts a fetch but never a store
        bus.inst_addr = 32'h0;
        bus.inst_req = 1'b1;
        tick();
        check("rb_a0", bus.mem_a, 32'h0);
        tick();
        check("rb_a1", bus.mem_a, 32'h1);
        bus.rollback = 1'b1;
        tick();
        check("rb_no_valid", 32'(bus.inst_valid), 32'd0);
        bus.rollback = 1'b0;
        bus.inst_req = 1'b0;
        wr_q.push_back('{32'h300, 8'h44});
        wr_q.push_back('{32'h301, 8'h33});
        wr_q.push_back('{32'h302, 8'h22});
        wr_q.push_back('{32'h303, 8'h11});
        ls_q.push_back('{1'b0, 32'd0});
        bus.ls_req = 1'b1;
        bus.ls_wr = 1'b1;
        bus.ls_size = 2'b10;
        bus.ls_addr = 32'h300;
        bus.ls_wdata = 32'h11223344;
        tick();
        check("rb_idle_accept", 32'(bus.mem_wr), 32'd1);
        check("rb_st_a0", bus.mem_a, 32'h300);
        bus.rollback = 1'b1;
        wait_ls("rb_st", 8);
        tick();
        bus.rollback = 1'b0;
        bus.ls_req = 1'b0;
        tick();
        check("rb_ram", {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]}, 32'h11223344);

        // 5. IO store held off while the IO buffer is full
        wr_q.push_back('{32'h30000, 8'hA5});
        ls_q.push_back('{1'b0, 32'd0});
        bus.io_buffer_full = 1'b1;
        bus.ls_req = 1'b1;
        bus.ls_wr = 1'b1;
        bus.ls_size = 2'b00;
        bus.ls_addr = 32'h30000;
        bus.ls_wdata = 32'h000000A5;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("io_held_wr", 32'(bus.mem_wr), 32'd0);
            check("io_held_done", 32'(bus.ls_done), 32'd0);
        end
        bus.io_buffer_full = 1'b0;
        wait_ls("io", 6);
        tick();
        bus.ls_req = 1'b0;
        tick();
        check("io_ram", {24'd0, ram[18'h30000]}, 32'hA5);

        // 6. rdy stall in the middle of a word load
        ls_q.push_back('{1'b1, 32'h12345678});
        bus.ls_req = 1'b1;
        bus.ls_wr = 1'b0;
        bus.ls_size = 2'b10;
        bus.ls_addr = 32'h400;
        tick();
        tick();
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_wr", 32'(bus.mem_wr), 32'd0);
            check("rdy_a_hold", bus.mem_a, 32'h401);
            check("rdy_no_done", 32'(bus.ls_done), 32'd0);
        end
        bus.rdy = 1'b1;
        wait_ls("rdy", 8);
        check("rdy_rdata", bus.ls_rdata, 32'h12345678);
        tick();
        bus.ls_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Nothing left outstanding
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        check("ls_q_empty", 32'(ls_q.size()), 32'd0);
        check("inst_q_empty", 32'(inst_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
